// File: rtl/minibus_arbiter.sv
// rtl/minibus_arbiter.sv - round-robin minibus arbiter, one outstanding transaction at a time
// Optional forced abort of stalled transactions when MINIBUS_ARBITER_TIMEOUT_EN is defined.
module minibus_arbiter #(
  parameter int MASTER_COUNT   = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int GW            = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [MASTER_COUNT*ADDR_W-1:0] m_req_addr,
  input  logic [MASTER_COUNT*DATA_W-1:0] m_req_wdata,
  input  logic [MASTER_COUNT-1:0]        m_req_ren,
  input  logic [MASTER_COUNT-1:0]        m_req_wen,
  output logic [DATA_W-1:0]              m_res_rdata,
  output logic [MASTER_COUNT-1:0]        m_res_ready,
  output logic [MASTER_COUNT-1:0]        m_res_error,
  output logic [ADDR_W-1:0]              d_req_addr,
  output logic [DATA_W-1:0]              d_req_wdata,
  output logic                           d_req_ren,
  output logic                           d_req_wen,
  input  logic [DATA_W-1:0]              d_res_rdata,
  input  logic                           d_res_ready,
  input  logic                           d_res_error,
  output logic [GW-1:0]                  grant_id
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state, state_next;
  logic [GW-1:0]           last_grant;
  logic [GW-1:0]           winner;
  logic                    any_req;
  logic                    found;
  logic [GW-1:0]           cand;
  logic [MASTER_COUNT-1:0] req;
  logic                    g_ren, g_wen, g_live, g_illegal;
  logic [ADDR_W-1:0]       g_addr;
  logic [DATA_W-1:0]       g_wdata;
  logic                    timeout_hit;
  logic                    busy_done;

  assign req       = m_req_ren | m_req_wen;
  assign any_req   = |req;
  assign g_ren     = m_req_ren[grant_id];
  assign g_wen     = m_req_wen[grant_id];
  assign g_live    = g_ren | g_wen;
  assign g_illegal = g_ren & g_wen;
  assign g_addr    = m_req_addr[grant_id*ADDR_W +: ADDR_W];
  assign g_wdata   = m_req_wdata[grant_id*DATA_W +: DATA_W];

  // Scan starts just after the last granted master, so it gets lowest priority.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < MASTER_COUNT; i++) begin
      cand = GW'((int'(last_grant) + 1 + i) % MASTER_COUNT);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

`ifdef MINIBUS_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || state == IDLE) begin
      tmo_cnt <= '0;
    end else if (!d_res_ready) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timeout_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign busy_done = !g_live || g_illegal || d_res_ready || timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= GW'(MASTER_COUNT - 1);
    end else begin
      state <= state_next;
      if (state == IDLE && any_req) begin
        grant_id <= winner;
      end
      if (state == BUSY && busy_done) begin
        last_grant <= grant_id;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = BUSY;
      BUSY:    if (busy_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m_res_rdata = '0;
    m_res_ready = '0;
    m_res_error = '0;
    d_req_addr  = '0;
    d_req_wdata = '0;
    d_req_ren   = 1'b0;
    d_req_wen   = 1'b0;
    if (state == BUSY && g_live) begin
      if (g_illegal) begin
        m_res_ready[grant_id] = 1'b1;
        m_res_error[grant_id] = 1'b1;
      end else if (!d_res_ready && timeout_hit) begin
        m_res_ready[grant_id] = 1'b1;
        m_res_error[grant_id] = 1'b1;
      end else begin
        d_req_addr  = g_addr;
        d_req_wdata = g_wdata;
        d_req_ren   = g_ren;
        d_req_wen   = g_wen;
        if (d_res_ready) begin
          m_res_ready[grant_id] = 1'b1;
          m_res_error[grant_id] = d_res_error;
          m_res_rdata           = d_res_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_minibus_arbiter.sv
// tb/tb_minibus_arbiter.sv - directed vector bench for minibus_arbiter
// Covers the timeout path when built with MINIBUS_ARBITER_TIMEOUT_EN.
module tb_minibus_arbiter;

  localparam int MC = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TMO = 8;
  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_0200;
  localparam logic [31:0] W0 = 32'h1111_1111;
  localparam logic [31:0] W1 = 32'h2222_2222;

  logic           clk = 1'b0;
  logic           rst;
  logic [MC*AW-1:0] m_req_addr;
  logic [MC*DW-1:0] m_req_wdata;
  logic [MC-1:0]  m_req_ren, m_req_wen;
  logic [DW-1:0]  m_res_rdata;
  logic [MC-1:0]  m_res_ready, m_res_error;
  logic [AW-1:0]  d_req_addr;
  logic [DW-1:0]  d_req_wdata;
  logic           d_req_ren, d_req_wen;
  logic [DW-1:0]  d_res_rdata;
  logic           d_res_ready, d_res_error;
  logic [0:0]     grant_id;

  minibus_arbiter #(
    .MASTER_COUNT(MC), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata),
    .m_req_ren(m_req_ren), .m_req_wen(m_req_wen),
    .m_res_rdata(m_res_rdata), .m_res_ready(m_res_ready), .m_res_error(m_res_error),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_req_ren(d_req_ren), .d_req_wen(d_req_wen),
    .d_res_rdata(d_res_rdata), .d_res_ready(d_res_ready), .d_res_error(d_res_error),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  ren, wen;
    logic        drdy, derr;
    logic [31:0] drdata;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_rdy, e_err;
    logic [31:0] e_rdata;
    logic        e_gid;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic [1:0] ren, input logic [1:0] wen,
                     input logic drdy, input logic derr, input logic [31:0] drdata,
                     input logic e_ren, input logic e_wen, input logic [31:0] e_addr,
                     input logic [31:0] e_wdata, input logic [1:0] e_rdy,
                     input logic [1:0] e_err, input logic [31:0] e_rdata, input logic e_gid);
    vec_t v;
    v.rst = r; v.ren = ren; v.wen = wen; v.drdy = drdy; v.derr = derr; v.drdata = drdata;
    v.e_ren = e_ren; v.e_wen = e_wen; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_rdy = e_rdy; v.e_err = e_err; v.e_rdata = e_rdata; v.e_gid = e_gid;
    vecs.push_back(v);
  endtask

  // Drive mid-cycle, sample 1ns later, well clear of the rising edge.
  task automatic apply(input vec_t v, input int idx);
    logic [133:0] act, exp;
    @(negedge clk);
    rst = v.rst; m_req_ren = v.ren; m_req_wen = v.wen;
    d_res_ready = v.drdy; d_res_error = v.derr; d_res_rdata = v.drdata;
    #1;
    act = {d_req_ren, d_req_wen, d_req_addr, d_req_wdata, m_res_ready, m_res_error, m_res_rdata, grant_id};
    exp = {v.e_ren, v.e_wen, v.e_addr, v.e_wdata, v.e_rdy, v.e_err, v.e_rdata, v.e_gid};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL vec%0d ren/wen/addr/wdata/rdy/err/rdata/gid actual=%h required=%h", idx, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    int seen;
    m_req_addr  = {A1, A0};
    m_req_wdata = {W1, W0};
    m_req_ren = '0; m_req_wen = '0;
    d_res_ready = 1'b0; d_res_error = 1'b0; d_res_rdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    //  rst ren    wen    rdy err rdata         eren ewen eaddr eWdata rdy    err    erdata        gid
    // single read, ready on 3rd BUSY cycle
    add(0, 2'b01, 2'b00, 0, 0, 32'h0,          0, 0, 0,  0,  2'b00, 2'b00, 32'h0,          0);
    add(0, 2'b01, 2'b00, 0, 0, 32'h0,          1, 0, A0, W0, 2'b00, 2'b00, 32'h0,          0);
    add(0, 2'b01, 2'b00, 0, 0, 32'h0,          1, 0, A0, W0, 2'b00, 2'b00, 32'h0,          0);
    add(0, 2'b01, 2'b00, 1, 0, 32'hDEADBEEF,   1, 0, A0, W0, 2'b01, 2'b00, 32'hDEADBEEF,   0);
    add(0, 2'b00, 2'b00, 0, 0, 32'h0,          0, 0, 0,  0,  2'b00, 2'b00, 32'h0,          0);
    // contention after reset: alternating 0,1,0,1
    add(1, 2'b00, 2'b00, 0, 0, 32'h0,          0, 0, 0,  0,  2'b00, 2'b00, 32'h0,          0);
    add(0, 2'b11, 2'b00, 0, 0, 32'h0,          0, 0, 0,  0,  2'b00, 2'b00, 32'h0,          0);
    add(0, 2'b11, 2'b00, 1, 0, 32'hA0,         1, 0, A0, W0, 2'b01, 2'b00, 32'hA0,         0);
    add(0, 2'b11, 2'b00, 0, 0, 32'h0,          0, 0, 0,  0,  2'b00, 2'b00, 32'h0,          0);
    add(0, 2'b11, 2'b00, 1, 0, 32'hB1,         1, 0, A1, W1, 2'b10, 2'b00, 32'hB1,         1);
    add(0, 2'b11, 2'b00, 0, 0, 32'h0,          0, 0, 0,  0,  2'b00, 2'b00, 32'h0,          1);
    add(0, 2'b11, 2'b00, 1, 0, 32'hC2,         1, 0, A0, W0, 2'b01, 2'b00, 32'hC2,         0);
    add(0, 2'b11, 2'b00, 0, 0, 32'h0,          0, 0, 0,  0,  2'b00, 2'b00, 32'h0,          0);
    add(0, 2'b11, 2'b00, 1, 0, 32'hD3,         1, 0, A1, W1, 2'b10, 2'b00, 32'hD3,         1);
    // illegal ren&wen from M1
    add(0, 2'b10, 2'b10, 0, 0, 32'h0,          0, 0, 0,  0,  2'b00, 2'b00, 32'h0,          1);
    add(0, 2'b10, 2'b10, 0, 0, 32'h0,          0, 0, 0,  0,  2'b10, 2'b10, 32'h0,          1);
    add(0, 2'b00, 2'b00, 0, 0, 32'h0,          0, 0, 0,  0,  2'b00, 2'b00, 32'h0,          1);
    // decoder error pass-through on M0 write
    add(0, 2'b00, 2'b01, 0, 0, 32'h0,          0, 0, 0,  0,  2'b00, 2'b00, 32'h0,          1);
    add(0, 2'b00, 2'b01, 1, 1, 32'h55,         0, 1, A0, W0, 2'b01, 2'b01, 32'h55,         0);
    // M1 drops its request before ready; stray decoder ready in IDLE is ignored
    add(0, 2'b10, 2'b00, 0, 0, 32'h0,          0, 0, 0,  0,  2'b00, 2'b00, 32'h0,          0);
    add(0, 2'b10, 2'b00, 0, 0, 32'h0,          1, 0, A1, W1, 2'b00, 2'b00, 32'h0,          1);
    add(0, 2'b00, 2'b00, 0, 0, 32'h0,          0, 0, 0,  0,  2'b00, 2'b00, 32'h0,          1);
    add(0, 2'b00, 2'b00, 1, 0, 32'h77,         0, 0, 0,  0,  2'b00, 2'b00, 32'h0,          1);
    // reset while an M0 write is in flight, then M1 alone wins
    add(0, 2'b00, 2'b01, 0, 0, 32'h0,          0, 0, 0,  0,  2'b00, 2'b00, 32'h0,          1);
    add(0, 2'b00, 2'b01, 0, 0, 32'h0,          0, 1, A0, W0, 2'b00, 2'b00, 32'h0,          0);
    add(1, 2'b00, 2'b01, 0, 0, 32'h0,          0, 1, A0, W0, 2'b00, 2'b00, 32'h0,          0);
    add(0, 2'b10, 2'b00, 1, 0, 32'h99,         0, 0, 0,  0,  2'b00, 2'b00, 32'h0,          0);
    add(0, 2'b10, 2'b00, 0, 0, 32'h0,          1, 0, A1, W1, 2'b00, 2'b00, 32'h0,          1);
    add(0, 2'b10, 2'b00, 1, 0, 32'h1234,       1, 0, A1, W1, 2'b10, 2'b00, 32'h1234,       1);
    add(0, 2'b00, 2'b00, 0, 0, 32'h0,          0, 0, 0,  0,  2'b00, 2'b00, 32'h0,          1);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Stalled decoder: M0 read, decoder never answers
    @(negedge clk);
    m_req_ren = 2'b01; d_res_ready = 1'b0; d_res_error = 1'b0; d_res_rdata = '0;
`ifdef MINIBUS_ARBITER_TIMEOUT_EN
    seen = 0;
    for (int k = 1; k < TMO; k++) begin
      @(negedge clk); #1;
      if (m_res_ready != 2'b00) seen++;
    end
    check1("tmo_early_ready", seen, 0);
    @(negedge clk); #1;
    check1("tmo_ready", {30'b0, m_res_ready}, 32'h1);
    check1("tmo_error", {30'b0, m_res_error}, 32'h1);
    check1("tmo_dreq", {30'b0, d_req_ren, d_req_wen}, 32'h0);
    m_req_ren = 2'b00;
    @(negedge clk); #1;
    check1("tmo_idle_after", {30'b0, m_res_ready}, 32'h0);
`else
    seen = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk); #1;
      if (m_res_ready != 2'b00 || !d_req_ren) seen++;
    end
    check1("no_timeout_1000", seen, 0);
    m_req_ren = 2'b00;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
